// File: rtl/mm_pkg.sv
// Shared types and constants for the Mastermind game sequencer.
//   - state_e   : 3-bit sequencer state; enumerator values double as the phase code
//   - PHASE_*   : phase codes shown on the 7-segment status display
//   - *_DEF     : default game limits
//   - POINT_W   : width of score/round buses, shared with the codebreaker
package mm_pkg;

  localparam int unsigned POINT_W = 2;

  localparam int unsigned WIN_PTS_DEF     = 3;
  localparam int unsigned MAX_ROUNDS_DEF  = 3;
  localparam int unsigned SHOW_CYCLES_DEF = 100;

  localparam logic [2:0] PHASE_IDLE  = 3'd0;
  localparam logic [2:0] PHASE_PICK  = 3'd1;
  localparam logic [2:0] PHASE_MAKE  = 3'd2;
  localparam logic [2:0] PHASE_BREAK = 3'd3;
  localparam logic [2:0] PHASE_SHOW  = 3'd4;
  localparam logic [2:0] PHASE_CHECK = 3'd5;
  localparam logic [2:0] PHASE_OVER  = 3'd6;

  typedef enum logic [2:0] {
    StIdle  = PHASE_IDLE,
    StPick  = PHASE_PICK,
    StMake  = PHASE_MAKE,
    StBreak = PHASE_BREAK,
    StShow  = PHASE_SHOW,
    StCheck = PHASE_CHECK,
    StOver  = PHASE_OVER
  } state_e;

endpackage

// File: rtl/mm_hold_timer.sv
// Load/done down-counter that holds the LED feedback on screen.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset (count -> 0)
//   i_load  : load CYCLES-1 on the next edge
//   o_done  : count is zero
// After a load the counter shows CYCLES-1 and reaches 0 after CYCLES-1 more edges,
// so a phase that leaves on o_done lasts exactly CYCLES cycles.
module mm_hold_timer #(
  parameter int unsigned CYCLES = 100
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  output logic o_done
);

  localparam int unsigned CntW    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(CYCLES - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LoadVal;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/mastermind_game_ctrl.sv
// Top-level game sequencer for the electronic Mastermind machine.
// Picks the first codemaker, hands turns to the codemaker-entry and codebreaker
// blocks, holds LED feedback for SHOW_CYCLES, and declares the game result.
// Inputs : i_clk, i_rst_n (async, active-low), i_start, i_enter_a/b (PICK buttons),
//          i_make_done, i_round_done, i_next_maker_a/b (valid with round_done),
//          i_pts_a/b, i_rounds (codebreaker score and round count).
// Outputs: o_make_en, o_maker_is_a, o_code_breaker, o_player_a/b, o_clr_scores, o_show,
//          o_game_over, o_winner_a/b, o_draw, o_phase (state code for display).
// All outputs are Moore: decoded from the state register or from registered flags.
module mastermind_game_ctrl
  import mm_pkg::*;
#(
  parameter int unsigned WIN_PTS     = WIN_PTS_DEF,
  parameter int unsigned MAX_ROUNDS  = MAX_ROUNDS_DEF,
  parameter int unsigned SHOW_CYCLES = SHOW_CYCLES_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_enter_a,
  input  logic               i_enter_b,
  input  logic               i_make_done,
  input  logic               i_round_done,
  input  logic               i_next_maker_a,
  input  logic               i_next_maker_b,
  input  logic [POINT_W-1:0] i_pts_a,
  input  logic [POINT_W-1:0] i_pts_b,
  input  logic [POINT_W-1:0] i_rounds,
  output logic               o_make_en,
  output logic               o_maker_is_a,
  output logic               o_code_breaker,
  output logic               o_player_a,
  output logic               o_player_b,
  output logic               o_clr_scores,
  output logic               o_show,
  output logic               o_game_over,
  output logic               o_winner_a,
  output logic               o_winner_b,
  output logic               o_draw,
  output logic [2:0]         o_phase
);

  localparam logic [POINT_W-1:0] WinPts    = POINT_W'(WIN_PTS);
  localparam logic [POINT_W-1:0] MaxRounds = POINT_W'(MAX_ROUNDS);

  state_e r_state, w_state_nxt;
  logic   r_maker_is_a, w_maker_is_a_nxt;
  logic   r_next_maker_a, w_next_maker_a_nxt;
  logic   r_winner_a, w_winner_a_nxt;
  logic   r_winner_b, w_winner_b_nxt;
  logic   r_draw, w_draw_nxt;
  logic   w_timer_load;
  logic   w_timer_done;
  logic   w_game_end;

  mm_hold_timer #(
    .CYCLES (SHOW_CYCLES)
  ) u_hold_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_timer_load),
    .o_done  (w_timer_done)
  );

  assign w_game_end = (i_pts_a >= WinPts) || (i_pts_b >= WinPts) || (i_rounds >= MaxRounds);

  always_comb begin
    w_state_nxt        = r_state;
    w_maker_is_a_nxt   = r_maker_is_a;
    w_next_maker_a_nxt = r_next_maker_a;
    w_winner_a_nxt     = r_winner_a;
    w_winner_b_nxt     = r_winner_b;
    w_draw_nxt         = r_draw;
    w_timer_load       = 1'b0;

    case (r_state)
      StIdle: begin
        if (i_start) w_state_nxt = StPick;
      end
      StPick: begin
        // A wins a same-cycle tie.
        if (i_enter_a || i_enter_b) begin
          w_maker_is_a_nxt = i_enter_a;
          w_state_nxt      = StMake;
        end
      end
      StMake: begin
        if (i_make_done) w_state_nxt = StBreak;
      end
      StBreak: begin
        if (i_round_done) begin
          if (i_next_maker_a)      w_next_maker_a_nxt = 1'b1;
          else if (i_next_maker_b) w_next_maker_a_nxt = 1'b0;
          else                     w_next_maker_a_nxt = ~r_maker_is_a;
          w_timer_load = 1'b1;
          w_state_nxt  = StShow;
        end
      end
      StShow: begin
        if (w_timer_done) w_state_nxt = StCheck;
      end
      StCheck: begin
        if (w_game_end) begin
          w_winner_a_nxt = (i_pts_a > i_pts_b);
          w_winner_b_nxt = (i_pts_a < i_pts_b);
          w_draw_nxt     = (i_pts_a == i_pts_b);
          w_state_nxt    = StOver;
        end else begin
          // Role change only takes effect once the round is confirmed not final.
          w_maker_is_a_nxt = r_next_maker_a;
          w_state_nxt      = StMake;
        end
      end
      StOver: begin
        if (i_start) begin
          w_winner_a_nxt = 1'b0;
          w_winner_b_nxt = 1'b0;
          w_draw_nxt     = 1'b0;
          w_state_nxt    = StPick;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_maker_is_a   <= 1'b0;
      r_next_maker_a <= 1'b0;
      r_winner_a     <= 1'b0;
      r_winner_b     <= 1'b0;
      r_draw         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_maker_is_a   <= w_maker_is_a_nxt;
      r_next_maker_a <= w_next_maker_a_nxt;
      r_winner_a     <= w_winner_a_nxt;
      r_winner_b     <= w_winner_b_nxt;
      r_draw         <= w_draw_nxt;
    end
  end

  assign o_make_en      = (r_state == StMake);
  assign o_maker_is_a   = r_maker_is_a;
  assign o_code_breaker = (r_state == StBreak);
  assign o_player_a     = o_code_breaker & ~r_maker_is_a;
  assign o_player_b     = o_code_breaker & r_maker_is_a;
  assign o_clr_scores   = (r_state == StPick);
  assign o_show         = (r_state == StShow);
  assign o_game_over    = (r_state == StOver);
  assign o_winner_a     = r_winner_a;
  assign o_winner_b     = r_winner_b;
  assign o_draw         = r_draw;
  assign o_phase        = r_state;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Self-checking bench for mastermind_game_ctrl: directed scenarios plus a randomized
// run, all checked against a game-rule model kept here.
module tb_mastermind_game_ctrl;

  localparam int SHOW = 100;
  localparam int WIN  = 3;
  localparam int MAXR = 3;

  // Model stage codes (the display phase codes).
  localparam int M_IDLE  = 0;
  localparam int M_PICK  = 1;
  localparam int M_MAKE  = 2;
  localparam int M_BREAK = 3;
  localparam int M_SHOW  = 4;
  localparam int M_CHECK = 5;
  localparam int M_OVER  = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, enter_a, enter_b, make_done, round_done, nm_a, nm_b;
  logic [1:0] pts_a, pts_b, rounds;
  logic       make_en, maker_is_a, code_breaker, player_a, player_b, clr_scores, show;
  logic       game_over, winner_a, winner_b, draw;
  logic [2:0] phase;
  logic [13:0] outs;

  int total = 0;
  int bad   = 0;

  int m_st;
  int m_show_n;
  bit m_maker_a, m_next_a, m_win_a, m_win_b, m_draw;

  always #5 clk = ~clk;

  mastermind_game_ctrl #(
    .WIN_PTS     (WIN),
    .MAX_ROUNDS  (MAXR),
    .SHOW_CYCLES (SHOW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_enter_a      (enter_a),
    .i_enter_b      (enter_b),
    .i_make_done    (make_done),
    .i_round_done   (round_done),
    .i_next_maker_a (nm_a),
    .i_next_maker_b (nm_b),
    .i_pts_a        (pts_a),
    .i_pts_b        (pts_b),
    .i_rounds       (rounds),
    .o_make_en      (make_en),
    .o_maker_is_a   (maker_is_a),
    .o_code_breaker (code_breaker),
    .o_player_a     (player_a),
    .o_player_b     (player_b),
    .o_clr_scores   (clr_scores),
    .o_show         (show),
    .o_game_over    (game_over),
    .o_winner_a     (winner_a),
    .o_winner_b     (winner_b),
    .o_draw         (draw),
    .o_phase        (phase)
  );

  assign outs = {make_en, maker_is_a, code_breaker, player_a, player_b, clr_scores, show,
                 game_over, winner_a, winner_b, draw, phase};

  task automatic model_reset();
    m_st = M_IDLE; m_show_n = 0;
    m_maker_a = 0; m_next_a = 0; m_win_a = 0; m_win_b = 0; m_draw = 0;
  endtask

  // Game rules applied to the inputs present at one rising edge.
  task automatic model_step();
    int pa, pb, rn;
    pa = int'(pts_a); pb = int'(pts_b); rn = int'(rounds);
    case (m_st)
      M_IDLE:  if (start) m_st = M_PICK;
      M_PICK:  if (enter_a || enter_b) begin m_maker_a = enter_a; m_st = M_MAKE; end
      M_MAKE:  if (make_done) m_st = M_BREAK;
      M_BREAK: if (round_done) begin
        m_next_a = nm_a ? 1'b1 : (nm_b ? 1'b0 : !m_maker_a);
        m_show_n = 0;
        m_st     = M_SHOW;
      end
      M_SHOW: begin
        m_show_n++;
        if (m_show_n == SHOW) m_st = M_CHECK;
      end
      M_CHECK: begin
        if (pa >= WIN || pb >= WIN || rn >= MAXR) begin
          m_win_a = (pa > pb); m_win_b = (pa < pb); m_draw = (pa == pb);
          m_st = M_OVER;
        end else begin
          m_maker_a = m_next_a;
          m_st = M_MAKE;
        end
      end
      M_OVER: if (start) begin m_win_a = 0; m_win_b = 0; m_draw = 0; m_st = M_PICK; end
      default: m_st = M_IDLE;
    endcase
  endtask

  function automatic logic [13:0] exp_outs();
    bit brk;
    logic [2:0] ph;
    brk = (m_st == M_BREAK);
    ph  = 3'(m_st);
    return {m_st == M_MAKE, m_maker_a, brk, brk && !m_maker_a, brk && m_maker_a,
            m_st == M_PICK, m_st == M_SHOW, m_st == M_OVER, m_win_a, m_win_b, m_draw, ph};
  endfunction

  task automatic clear_pulses();
    start = 0; enter_a = 0; enter_b = 0; make_done = 0; round_done = 0;
  endtask

  // One clock: model advances on the edge, bench returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    clear_pulses();
  endtask

  task automatic run_until_phase(input int target, input int budget);
    for (int i = 0; i < budget && int'(phase) != target; i++) tick();
  endtask

  task automatic test_reset();
    total++;
    if (outs !== 14'd0) begin
      bad++; $display("FAIL reset_outs: got %b want %b", outs, 14'd0);
    end
    rst_n = 1;
    tick();
    total++;
    if (outs !== exp_outs()) begin
      bad++; $display("FAIL reset_idle: got %b want %b", outs, exp_outs());
    end
  endtask

  task automatic test_pick_arbitration();
    start = 1; tick();
    total++;
    if (phase !== 3'd1 || clr_scores !== 1'b1 || outs !== exp_outs()) begin
      bad++; $display("FAIL pick_enter: got %b want %b", outs, exp_outs());
    end
    enter_a = 1; enter_b = 1; tick();
    total++;
    if (maker_is_a !== 1'b1 || phase !== 3'd2 || outs !== exp_outs()) begin
      bad++; $display("FAIL pick_tie_a: got %b want %b", outs, exp_outs());
    end
    make_done = 1; tick();
    total++;
    if (player_b !== 1'b1 || player_a !== 1'b0 || phase !== 3'd3 || outs !== exp_outs()) begin
      bad++; $display("FAIL break_roles: got %b want %b", outs, exp_outs());
    end
  endtask

  task automatic test_normal_round();
    int n;
    n = 0;
    round_done = 1; nm_a = 0; nm_b = 1; pts_a = 2'd1; pts_b = 2'd0; rounds = 2'd1;
    tick();
    for (int i = 0; i < SHOW + 10 && show === 1'b1; i++) begin
      n++;
      total++;
      if (outs !== exp_outs()) begin
        bad++; $display("FAIL show_cycle%0d: got %b want %b", i, outs, exp_outs());
      end
      tick();
    end
    total++;
    if (n !== SHOW) begin
      bad++; $display("FAIL show_len: got %0d want %0d", n, SHOW);
    end
    total++;
    if (phase !== 3'd5 || outs !== exp_outs()) begin
      bad++; $display("FAIL check_phase: got %b want %b", outs, exp_outs());
    end
    tick();
    total++;
    if (phase !== 3'd2 || maker_is_a !== 1'b0 || outs !== exp_outs()) begin
      bad++; $display("FAIL make_next_b: got %b want %b", outs, exp_outs());
    end
  endtask

  task automatic test_swap();
    make_done = 1; tick();
    round_done = 1; nm_a = 1; nm_b = 0; tick();
    run_until_phase(M_MAKE, SHOW + 5);
    total++;
    if (maker_is_a !== 1'b1 || outs !== exp_outs()) begin
      bad++; $display("FAIL next_a: got %b want %b", outs, exp_outs());
    end
    make_done = 1; tick();
    round_done = 1; nm_a = 0; nm_b = 0; tick();
    run_until_phase(M_MAKE, SHOW + 5);
    total++;
    if (maker_is_a !== 1'b0 || phase !== 3'd2 || outs !== exp_outs()) begin
      bad++; $display("FAIL swap_roles: got %b want %b", outs, exp_outs());
    end
  endtask

  task automatic test_win_points();
    make_done = 1; tick();
    pts_a = 2'd3; pts_b = 2'd1; rounds = 2'd2; round_done = 1; nm_a = 0; nm_b = 0;
    tick();
    run_until_phase(M_OVER, SHOW + 5);
    total++;
    if (game_over !== 1'b1 || winner_a !== 1'b1 || winner_b !== 1'b0 || draw !== 1'b0 ||
        outs !== exp_outs()) begin
      bad++; $display("FAIL win_a: got %b want %b", outs, exp_outs());
    end
    make_done = 1; tick();
    total++;
    if (phase !== 3'd6 || make_en !== 1'b0 || outs !== exp_outs()) begin
      bad++; $display("FAIL over_ignores: got %b want %b", outs, exp_outs());
    end
  endtask

  task automatic test_draw_rounds();
    start = 1; tick();
    total++;
    if (phase !== 3'd1 || {winner_a, winner_b, draw, game_over} !== 4'b0 ||
        outs !== exp_outs()) begin
      bad++; $display("FAIL restart: got %b want %b", outs, exp_outs());
    end
    enter_b = 1; tick();
    total++;
    if (maker_is_a !== 1'b0 || outs !== exp_outs()) begin
      bad++; $display("FAIL pick_b: got %b want %b", outs, exp_outs());
    end
    make_done = 1; tick();
    pts_a = 2'd1; pts_b = 2'd1; rounds = 2'd3; round_done = 1; tick();
    run_until_phase(M_OVER, SHOW + 5);
    total++;
    if (draw !== 1'b1 || winner_a !== 1'b0 || winner_b !== 1'b0 || game_over !== 1'b1 ||
        outs !== exp_outs()) begin
      bad++; $display("FAIL draw: got %b want %b", outs, exp_outs());
    end
    start = 1; tick();
    total++;
    if (phase !== 3'd1 || clr_scores !== 1'b1 || {winner_a, winner_b, draw} !== 3'b0 ||
        outs !== exp_outs()) begin
      bad++; $display("FAIL clear_flags: got %b want %b", outs, exp_outs());
    end
  endtask

  task automatic test_reset_mid_break();
    pts_a = 0; pts_b = 0; rounds = 0;
    enter_a = 1; tick();
    make_done = 1; tick();
    total++;
    if (code_breaker !== 1'b1 || outs !== exp_outs()) begin
      bad++; $display("FAIL pre_reset_break: got %b want %b", outs, exp_outs());
    end
    #2 rst_n = 0;
    #1;
    model_reset();
    total++;
    if (outs !== 14'd0) begin
      bad++; $display("FAIL async_reset: got %b want %b", outs, 14'd0);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    total++;
    if (outs !== exp_outs()) begin
      bad++; $display("FAIL post_reset: got %b want %b", outs, exp_outs());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      enter_a    = ($urandom_range(0, 3) == 0);
      enter_b    = ($urandom_range(0, 3) == 0);
      make_done  = ($urandom_range(0, 3) == 0);
      round_done = ($urandom_range(0, 3) == 0);
      nm_a       = 1'($urandom_range(0, 1));
      nm_b       = 1'($urandom_range(0, 1));
      pts_a      = 2'($urandom_range(0, 3));
      pts_b      = 2'($urandom_range(0, 3));
      rounds     = 2'($urandom_range(0, 3));
      tick();
      total++;
      if (outs !== exp_outs()) begin
        bad++; $display("FAIL random_cyc%0d: got %b want %b", i, outs, exp_outs());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    clear_pulses();
    nm_a = 0; nm_b = 0; pts_a = 0; pts_b = 0; rounds = 0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_pick_arbitration();
    test_normal_round();
    test_swap();
    test_win_points();
    test_draw_rounds();
    test_reset_mid_break();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mastermind_game_ctrl.md
# mastermind_game_ctrl

Top-level game sequencer for the electronic Mastermind machine. It arbitrates which player becomes the first codemaker and hands the codemaker-entry and codebreaker blocks their turns in order. It holds each round's LED feedback on screen for a fixed time, tracks the score and round limits reported by the codebreaker, and declares game over with a winner or a draw. It sits above the codemaker-entry block and the codebreaker block and drives their enable and role-select inputs.

## Interface
- WIN_PTS, 3: points that end the game immediately; legal range 1..3.
- MAX_ROUNDS, 3: finalized rounds that end the game; legal range 1..3.
- SHOW_CYCLES, 100: clock cycles the SHOW phase lasts; must be ≥1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a game from IDLE or OVER.
- enterA, enterB  in  1  one-cycle player button pulses; used only in PICK.
- make_done  in  1  one-cycle pulse from the codemaker-entry block: code latched.
- round_done  in  1  one-cycle pulse from the codebreaker: round finalized.
- next_maker_A, next_maker_B  in  1  codebreaker's choice of next codemaker; valid with round_done.
- pts_A, pts_B  in  2  current scores from the codebreaker.
- rounds  in  2  finalized-round count from the codebreaker.
- make_en  out  1  codemaker-entry enable.
- maker_is_A  out  1  1 when player A is codemaker.
- codeBreaker  out  1  codebreaker enable.
- player_A, player_B  out  1  codebreaker identity; one-hot while codeBreaker is 1, otherwise both 0.
- clr_scores  out  1  forces the score and round sources to 0.
- show  out  1  LED feedback display hold.
- game_over, winner_A, winner_B, draw  out  1  result flags.
- phase  out  3  current state code, for the 7-segment status display.

## Operation
- States: IDLE, PICK, MAKE, BREAK, SHOW, CHECK, OVER.
- IDLE: start → PICK.
- PICK:
  - clr_scores=1.
  - The first enterA or enterB pulse sets maker_is_A to 1 for A, 0 for B, then → MAKE.
  - Both pulses in the same cycle: A wins.
- MAKE: make_en=1; make_done → BREAK.
- BREAK:
  - codeBreaker=1.
  - player_A = ~maker_is_A; player_B = maker_is_A.
  - round_done → SHOW and latches the next codemaker:
    - next_maker_A=1 → A (this takes priority when both flags are 1);
    - else next_maker_B=1 → B;
    - neither flag set → roles swap.
- SHOW: show=1; the hold timer loads SHOW_CYCLES-1 on entry and counts to 0, then → CHECK.
- CHECK: single cycle.
  - pts_A ≥ WIN_PTS, pts_B ≥ WIN_PTS, or rounds ≥ MAX_ROUNDS → OVER.
  - Otherwise → MAKE, with maker_is_A updated to the latched next codemaker.
- OVER:
  - game_over=1.
  - pts_A > pts_B → winner_A; pts_A < pts_B → winner_B; equal → draw. Flags are registered on entry and held.
  - start → PICK, which clears the flags.
- Inputs that are not listed for the current state are ignored. This includes start outside IDLE/OVER, round_done outside BREAK, and make_done outside MAKE.
- Comparisons are unsigned 2-bit. rounds wraps 3→0 upstream; MAX_ROUNDS ≤3 makes ≥ safe before the wrap.

## Timing
- All outputs are Moore outputs, decoded from the state register or from registered flags. An output changes on the edge after its triggering input is sampled; there is no combinational input-to-output path.
- Reset: state=IDLE, timer=0, and every output is 0, including maker_is_A, phase and the result flags.
- Reset asserted mid-game returns the block to IDLE immediately (asynchronously); no partial round is kept.
- SHOW lasts exactly SHOW_CYCLES cycles. CHECK lasts 1 cycle.
- round_done → MAKE of the next round takes SHOW_CYCLES+2 edges.
- phase encoding: IDLE=0, PICK=1, MAKE=2, BREAK=3, SHOW=4, CHECK=5, OVER=6. Code 7 is unreachable; if it is ever decoded, the next state is IDLE.

## Structure
- Package mm_pkg holds:
  - the state enum (3-bit) and the phase constants;
  - the default WIN_PTS, MAX_ROUNDS and SHOW_CYCLES values;
  - the POINT_W=2 constant, shared with the codebreaker.
- Sub-module mm_hold_timer:
  - load/done down-counter;
  - width is $clog2(SHOW_CYCLES) with a minimum of 1.
- FSM, role latch and result flags stay in the top file.

## Test plan
- Reset mid-BREAK: reset=0 while codeBreaker=1 → all outputs 0 and phase=0 in the same cycle, without waiting for a clock edge.
- PICK arbitration: start, then enterA and enterB in the same cycle → maker_is_A=1, phase=2, with player_B=1 once in BREAK.
- Normal round: make_done, then round_done with next_maker_B=1, pts_A=1, pts_B=0, rounds=1:
  - show=1 for exactly 100 cycles;
  - CHECK, then MAKE with maker_is_A=0.
- Neither next_maker flag at round_done with maker_is_A=1 → maker_is_A=0 in the next MAKE.
- Win by points: pts_A=3 at CHECK → OVER, winner_A=1, game_over=1; a later make_done pulse is ignored.
- Draw by rounds: rounds=3, pts_A=1, pts_B=1 → draw=1. A later start → PICK with clr_scores=1 and all result flags cleared.
